// File: rtl/sdr_wb_burst_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdr_wb_burst_master_if
// Description : Client command/data handshake plus Wishbone master bus for
//               sdr_wb_burst_master. The master modport is the burst master's
//               view; the slave modport is the view of whatever drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdr_wb_burst_master_if #(
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int LEN_W  = 8
);
    // Client command channel
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_wr;
    logic [APP_AW-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic [dw/8-1:0]     cmd_sel;
    // Client write data stream
    logic                wdata_valid;
    logic                wdata_ready;
    logic [dw-1:0]       wdata;
    // Client read data stream and completion status
    logic                rd_valid;
    logic [dw-1:0]       rd_data;
    logic                rd_last;
    logic                done;
    logic                err;
    // Wishbone master side
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [APP_AW-1:0]   wb_addr_o;
    logic [dw-1:0]       wb_dat_o;
    logic [dw/8-1:0]     wb_sel_o;
    logic [2:0]          wb_cti_o;
    logic                wb_ack_i;
    logic [dw-1:0]       wb_dat_i;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_sel,
        input  wdata_valid, wdata, wb_ack_i, wb_dat_i,
        output cmd_ready, wdata_ready, rd_valid, rd_data, rd_last, done, err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_sel,
        output wdata_valid, wdata, wb_ack_i, wb_dat_i,
        input  cmd_ready, wdata_ready, rd_valid, rd_data, rd_last, done, err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
    );
endinterface
`default_nettype wire

// File: rtl/sdr_wb_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdr_wb_burst_master
// Description : Single-command Wishbone incrementing-burst master. Streams
//               write data through a one-entry holding register, returns read
//               beats unthrottled, and aborts a burst on an ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sdr_wb_burst_master #(
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int LEN_W  = 8,
    parameter int TO_W   = 8
) (
    input  wire logic               wb_clk_i,
    input  wire logic               reset_n,
    sdr_wb_burst_master_if.master   bus
);

    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_WR      = 2'd1;
    localparam logic [1:0]        c_RD      = 2'd2;
    localparam logic [LEN_W:0]    c_ONE     = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0]    c_FULL    = {1'b1, {LEN_W{1'b0}}};
    localparam logic [TO_W-1:0]   c_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [APP_AW-1:0] c_STEP    = APP_AW'(4);
    localparam logic [APP_AW-1:0] c_AMASK   = ~APP_AW'(3);

    logic [1:0]         state_q, state_d;
    logic [APP_AW-1:0]  addr_q;
    logic [dw/8-1:0]    sel_q;
    logic [LEN_W:0]     rem_q;       // beats still to be acked
    logic [LEN_W:0]     fetch_q;     // write beats still to be taken from the client
    logic [dw-1:0]      hold_q;
    logic               hold_full_q;
    logic [TO_W-1:0]    to_q;
    logic               rd_valid_q, rd_last_q, done_q, err_q;
    logic [dw-1:0]      rd_data_q;

    logic               w_stb;
    logic               w_ack;
    logic               w_last_ack;
    logic               w_timeout;
    logic               w_accept;
    logic               w_wtake;
    logic [LEN_W:0]     w_len;

    // An ack only counts while a strobe is actually presented.
    assign w_ack      = w_stb & bus.wb_ack_i;
    assign w_last_ack = w_ack & (rem_q == c_ONE);
    assign w_timeout  = w_stb & ~bus.wb_ack_i & (to_q == c_TO_LAST);
    assign w_accept   = (state_q == c_IDLE) & bus.cmd_valid;
    assign w_len      = (bus.cmd_len == '0) ? c_FULL : {1'b0, bus.cmd_len};

    // The holding register may be refilled in the same cycle its beat is acked.
    assign bus.wdata_ready = (state_q == c_WR) & (fetch_q != '0) & (~hold_full_q | w_ack);
    assign w_wtake         = bus.wdata_ready & bus.wdata_valid;

    assign bus.wb_stb_o  = w_stb;
    assign bus.wb_addr_o = addr_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_dat_o  = hold_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // State register.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on a command, return on the final ack or a timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = bus.cmd_wr ? c_WR : c_RD;
                end
            end
            c_WR, c_RD: begin
                if (w_last_ack || w_timeout) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Bus control outputs decoded from the current state.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.wb_cyc_o  = 1'b0;
        bus.wb_we_o   = 1'b0;
        bus.wb_cti_o  = 3'b000;
        w_stb         = 1'b0;
        case (state_q)
            c_IDLE: bus.cmd_ready = 1'b1;
            c_WR: begin
                bus.wb_cyc_o = 1'b1;
                bus.wb_we_o  = 1'b1;
                w_stb        = hold_full_q;
                bus.wb_cti_o = (rem_q == c_ONE) ? 3'b111 : 3'b010;
            end
            c_RD: begin
                bus.wb_cyc_o = 1'b1;
                w_stb        = 1'b1;
                bus.wb_cti_o = (rem_q == c_ONE) ? 3'b111 : 3'b010;
            end
            default: ;
        endcase
    end

    // Command capture, address increment and beat countdown.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            sel_q   <= '0;
            rem_q   <= '0;
        end else if (w_accept) begin
            addr_q  <= bus.cmd_addr & c_AMASK;
            sel_q   <= bus.cmd_sel;
            rem_q   <= w_len;
        end else if (w_ack) begin
            addr_q  <= addr_q + c_STEP;
            rem_q   <= rem_q - c_ONE;
        end
    end

    // Write holding register; emptied on ack and flushed on timeout.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            fetch_q     <= '0;
        end else if (w_accept) begin
            hold_full_q <= 1'b0;
            fetch_q     <= bus.cmd_wr ? w_len : '0;
        end else if (w_timeout) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            fetch_q     <= '0;
        end else if (w_wtake) begin
            hold_q      <= bus.wdata;
            hold_full_q <= 1'b1;
            fetch_q     <= fetch_q - c_ONE;
        end else if (w_ack) begin
            hold_full_q <= 1'b0;
        end
    end

    // Read beat return and completion status pulse.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == c_RD) & w_ack;
            rd_last_q  <= (state_q == c_RD) & w_last_ack;
            if ((state_q == c_RD) && w_ack) begin
                rd_data_q <= bus.wb_dat_i;
            end
            done_q     <= w_last_ack | w_timeout;
            err_q      <= w_timeout;
        end
    end

    // Ack wait counter: runs while a strobe waits, clears otherwise.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            to_q <= '0;
        end else if (w_stb && !bus.wb_ack_i && !w_timeout) begin
            to_q <= to_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_q <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdr_wb_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdr_wb_burst_master
// Description : Directed vector bench for sdr_wb_burst_master: a table of
//               burst commands with hand-computed outcomes plus reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdr_wb_burst_master;

    localparam int APP_AW = 26;
    localparam int DW     = 32;
    localparam int LEN_W  = 8;
    localparam int TO_W   = 8;

    logic wb_clk_i = 1'b0;
    logic reset_n  = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    sdr_wb_burst_master_if #(.APP_AW(APP_AW), .dw(DW), .LEN_W(LEN_W)) bus ();

    sdr_wb_burst_master #(
        .APP_AW (APP_AW),
        .dw     (DW),
        .LEN_W  (LEN_W),
        .TO_W   (TO_W)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    typedef struct {
        logic               wr;
        logic [APP_AW-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [3:0]         sel;
        int                 ack_wait;     // stb cycles without ack before each ack
        int                 gap_len;      // wdata_valid low cycles after the first write beat
        logic               stray;        // drive ack while cyc=1, stb=0
        int                 abort_after;  // withhold ack after this many beats (-1: never)
        logic [31:0]        dbase;        // beat i carries dbase+i
        int                 exp_beats;
        logic               exp_err;
        int                 exp_lat;      // cycles from accept edge to done, inclusive
        int                 exp_stb_low;  // cycles with cyc=1, stb=0
        logic [APP_AW-1:0]  exp_last;     // address of the last acked beat
    } vec_t;

    vec_t vecs[8];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one command from the current cycle; returns just after done is sampled.
    task automatic run_cmd(input vec_t v);
        logic [APP_AW-1:0] base;
        logic [APP_AW-1:0] exp_addr;
        logic [APP_AW-1:0] last_addr;
        int nb, pushed, acked, rcvd, wcnt, gapcnt, lat, stb_low, cyc_drop;
        logic withhold, ack, in_gap, seen_done;
        base      = v.addr & 26'h3FFFFFC;
        nb        = (v.len == 0) ? 256 : int'(v.len);
        pushed    = 0; acked = 0; rcvd = 0; wcnt = 0; gapcnt = 0;
        lat       = 0; stb_low = 0; cyc_drop = 0;
        seen_done = 1'b0;
        last_addr = '0;
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_cyc", bus.wb_cyc_o, 0);
        chk("idle_wdata_ready", bus.wdata_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_len   = v.len;
        bus.cmd_sel   = v.sel;
        @(posedge wb_clk_i);
        for (int k = 0; k < 3000 && !seen_done; k++) begin
            @(negedge wb_clk_i);
            bus.cmd_valid = 1'b0;
            lat++;
            withhold = (v.abort_after >= 0) && (acked == v.abort_after);
            ack = bus.wb_stb_o && (wcnt == v.ack_wait) && !withhold;
            bus.wb_ack_i = ack || (v.stray && bus.wb_cyc_o && !bus.wb_stb_o);
            bus.wb_dat_i = v.dbase + 32'(acked);
            in_gap = (pushed == 1) && (gapcnt < v.gap_len);
            if (in_gap) gapcnt++;
            bus.wdata_valid = v.wr && (pushed < nb) && !in_gap;
            bus.wdata = v.dbase + 32'(pushed);
            #1;
            if (bus.wdata_valid && bus.wdata_ready) pushed++;
            if (bus.rd_valid) begin
                chk("rd_data", bus.rd_data, v.dbase + 32'(rcvd));
                chk("rd_last", bus.rd_last, (rcvd == nb - 1));
                rcvd++;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                chk("done_err", bus.err, v.exp_err);
                chk("done_cmd_ready", bus.cmd_ready, 1);
                chk("done_cyc", bus.wb_cyc_o, 0);
                chk("done_stb", bus.wb_stb_o, 0);
            end else begin
                if (!bus.wb_cyc_o) cyc_drop++;
                if (!bus.wb_stb_o) stb_low++;
                if (ack) begin
                    exp_addr = base + 26'(4 * acked);
                    chk("beat_addr", bus.wb_addr_o, exp_addr);
                    chk("beat_cti", bus.wb_cti_o, (acked == nb - 1) ? 3'b111 : 3'b010);
                    chk("beat_we", bus.wb_we_o, v.wr);
                    chk("beat_sel", bus.wb_sel_o, v.sel);
                    if (v.wr) chk("beat_wdat", bus.wb_dat_o, v.dbase + 32'(acked));
                    last_addr = exp_addr;
                    acked++;
                    wcnt = 0;
                end else if (bus.wb_stb_o) begin
                    wcnt++;
                end
            end
        end
        bus.wb_ack_i    = 1'b0;
        bus.wdata_valid = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("beats_acked", acked, v.exp_beats);
        chk("rd_beats", rcvd, v.wr ? 0 : v.exp_beats);
        if (v.wr) chk("wr_taken", pushed, v.exp_beats);
        chk("last_addr", last_addr, v.exp_last);
        chk("latency", lat, v.exp_lat);
        chk("stb_low_cycles", stb_low, v.exp_stb_low);
        chk("cyc_held", cyc_drop, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr          len   sel   wt gap stray abort dbase        beats err lat  low last
        vecs[0] = '{1'b1, 26'h0000100, 8'd4, 4'hF, 0, 0, 1'b0, -1, 32'h000000A0, 4,   1'b0, 6,   1, 26'h000010C};
        vecs[1] = '{1'b0, 26'h3FFFFFC, 8'd2, 4'hF, 2, 0, 1'b0, -1, 32'h11110000, 2,   1'b0, 7,   0, 26'h0000000};
        vecs[2] = '{1'b1, 26'h0000200, 8'd3, 4'h3, 0, 5, 1'b1, -1, 32'hB0B00010, 3,   1'b0, 10,  6, 26'h0000208};
        vecs[3] = '{1'b0, 26'h0000040, 8'd8, 4'hF, 0, 0, 1'b0,  2, 32'h22220000, 2,   1'b1, 258, 0, 26'h0000044};
        vecs[4] = '{1'b0, 26'h0001000, 8'd0, 4'hF, 0, 0, 1'b0, -1, 32'h33330000, 256, 1'b0, 257, 0, 26'h00013FC};
        vecs[5] = '{1'b1, 26'h3FFFFF8, 8'd1, 4'h5, 1, 0, 1'b0, -1, 32'hC0000000, 1,   1'b0, 4,   1, 26'h3FFFFF8};
        vecs[6] = '{1'b1, 26'h3FFFFFC, 8'd2, 4'hC, 1, 0, 1'b0, -1, 32'hD0000000, 2,   1'b0, 6,   1, 26'h0000000};
        vecs[7] = '{1'b0, 26'h0000023, 8'd3, 4'h8, 0, 0, 1'b0, -1, 32'h44440000, 3,   1'b0, 4,   0, 26'h0000028};

        bus.cmd_valid   = 1'b0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.cmd_sel     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_dat_i    = '0;

        // Reset state, then 20 quiet cycles
        repeat (3) @(negedge wb_clk_i);
        #1;
        chk("rst_addr", bus.wb_addr_o, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wdata_ready", bus.wdata_ready, 0);
        @(negedge wb_clk_i);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk_i);
            #1;
            chk("quiet_cmd_ready", bus.cmd_ready, 1);
            chk("quiet_cyc", bus.wb_cyc_o, 0);
            chk("quiet_stb", bus.wb_stb_o, 0);
            chk("quiet_cti", bus.wb_cti_o, 3'b000);
            chk("quiet_done", bus.done, 0);
        end

        // Table of bursts, issued back to back (each starts in the done cycle of the last)
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i]);
        end

        // Reset asserted in the middle of a read burst
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = 26'h0000500;
        bus.cmd_len   = 8'd8;
        bus.cmd_sel   = 4'hF;
        @(posedge wb_clk_i);
        for (int i = 0; i < 2; i++) begin
            @(negedge wb_clk_i);
            bus.cmd_valid = 1'b0;
            bus.wb_ack_i  = 1'b1;
        end
        @(negedge wb_clk_i);
        bus.wb_ack_i = 1'b0;
        #1;
        chk("midrst_cyc_before", bus.wb_cyc_o, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_cyc", bus.wb_cyc_o, 0);
        chk("midrst_stb", bus.wb_stb_o, 0);
        chk("midrst_cti", bus.wb_cti_o, 3'b000);
        chk("midrst_addr", bus.wb_addr_o, 0);
        chk("midrst_rd_valid", bus.rd_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            #1;
            chk("midrst_no_done", bus.done, 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge wb_clk_i);
            #1;
            chk("postrst_cmd_ready", bus.cmd_ready, 1);
            chk("postrst_done", bus.done, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
